// File: rtl/gpio_irq_arbiter_if.sv
// gpio_irq_arbiter_if: IRQ/ACK handshake between the GPIO interrupt arbiter and the core.
//
// Signals:
//   irq     - interrupt request to the core
//   irq_id  - index of the requesting pin, valid while irq=1
//   irq_ack - core acknowledge, only observed while irq=1
//
// Modports:
//   master - arbiter side (drives irq/irq_id, samples irq_ack)
//   slave  - core side
//
// ID_W must match the ID_W of the gpio_irq_arbiter instance it is attached to.

interface gpio_irq_arbiter_if #(
    parameter int unsigned ID_W = 5
);
    logic            irq;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;

    modport master (
        output irq,
        output irq_id,
        input  irq_ack
    );

    modport slave (
        input  irq,
        input  irq_id,
        output irq_ack
    );
endinterface

// File: rtl/gpio_irq_arbiter.sv
// gpio_irq_arbiter: masks the per-pin GPIO interrupt lines, arbitrates them down to a single
// interrupt ID, presents it to the core over an IRQ/ACK handshake, then pulses the matching
// irqres clear strobe and checks that the source actually dropped.
//
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   intr      - per-pin latched interrupt levels from the pin mux
//   irq_mask  - per-pin enable, 1 = source may raise an interrupt
//   irqres    - per-pin clear strobe back to the pin mux (one-hot, one cycle)
//   pending   - registered intr & irq_mask for status readback
//   clr_err   - sticky: a source stayed high CLR_WAIT cycles after its clear strobe
//   err_clr   - clears clr_err (a simultaneous new error wins)
//   bus       - IRQ/ACK handshake to the core (master side)
//
// Build option:
//   GPIO_IRQ_RR_EN - when defined, round-robin arbitration starting after the last
//                    acknowledged ID; otherwise fixed priority, lowest index wins.
//
// Parameters: NUM_PINS sources, ID_W-bit IDs (2**ID_W >= NUM_PINS), CLR_WAIT >= 1.

module gpio_irq_arbiter #(
    parameter int unsigned NUM_PINS = 24,
    parameter int unsigned ID_W     = 5,
    parameter int unsigned CLR_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_PINS-1:0] intr,
    input  logic [NUM_PINS-1:0] irq_mask,
    output logic [NUM_PINS-1:0] irqres,
    output logic [NUM_PINS-1:0] pending,
    output logic                clr_err,
    input  logic                err_clr,
    gpio_irq_arbiter_if.master  bus
);

    localparam int unsigned CNT_W = (CLR_WAIT > 1) ? $clog2(CLR_WAIT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StClear,
        StWaitLow
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_PINS-1:0] intr_q;
    logic [NUM_PINS-1:0] pend;
    logic [NUM_PINS-1:0] pending_q;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                clr_err_q, clr_err_d;
    logic                err_set;
    logic                ack_take;
    logic [NUM_PINS-1:0] id_onehot;
    logic                win_found;
    logic [ID_W-1:0]     win_id;

    // Mask is applied after the input register so mask changes act on the very next decision.
    assign pend      = intr_q & irq_mask;
    assign id_onehot = NUM_PINS'(1) << id_q;

`ifdef GPIO_IRQ_RR_EN
    logic [ID_W-1:0]       last_id_q;
    logic [ID_W-1:0]       rr_base;
    logic [2*NUM_PINS-1:0] rr_dbl;
    int unsigned           rr_sum;

    // Rotate pend so the search start lands at bit 0, find the lowest set bit, then
    // map the offset back to a pin index with a single wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_sum    = 0;
        rr_base   = (last_id_q == ID_W'(NUM_PINS - 1)) ? '0 : last_id_q + 1'b1;
        rr_dbl    = {pend, pend} >> rr_base;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (rr_dbl[i]) begin
                win_found = 1'b1;
                rr_sum    = int'(unsigned'(rr_base)) + i;
            end
        end
        if (rr_sum >= NUM_PINS) begin
            rr_sum = rr_sum - NUM_PINS;
        end
        win_id = ID_W'(rr_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_q <= ID_W'(NUM_PINS - 1);
        end else if (ack_take) begin
            last_id_q <= id_q;
        end
    end
`else
    // Downward scan so the lowest set index is the last (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        err_set   = 1'b0;
        ack_take  = 1'b0;
        irqres    = '0;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    id_d    = win_id;
                    state_d = StReq;
                end
            end
            StReq: begin
                // ACK takes precedence over a source withdrawing in the same cycle.
                if (bus.irq_ack) begin
                    ack_take = 1'b1;
                    state_d  = StClear;
                end else if ((pend & id_onehot) == '0) begin
                    state_d = StIdle;
                end
            end
            StClear: begin
                irqres  = id_onehot;
                cnt_d   = '0;
                state_d = StWaitLow;
            end
            StWaitLow: begin
                // intr_q lags the pin mux by a cycle, so the first look may still be high.
                if ((intr_q & id_onehot) == '0) begin
                    state_d = StIdle;
                end else if (cnt_q == CNT_W'(CLR_WAIT - 1)) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (err_set) begin
            clr_err_d = 1'b1;
        end else if (err_clr) begin
            clr_err_d = 1'b0;
        end else begin
            clr_err_d = clr_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            intr_q    <= '0;
            pending_q <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            clr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            intr_q    <= intr;
            pending_q <= pend;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            clr_err_q <= clr_err_d;
        end
    end

    assign bus.irq    = (state_q == StReq);
    assign bus.irq_id = id_q;
    assign pending    = pending_q;
    assign clr_err    = clr_err_q;

endmodule

// File: tb/tb_gpio_irq_arbiter.sv
// Directed bench for gpio_irq_arbiter (NUM_PINS=24, ID_W=5, CLR_WAIT=4).
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.

module tb_gpio_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] intr;
    logic [23:0] irq_mask;
    logic [23:0] irqres;
    logic [23:0] pending;
    logic        clr_err;
    logic        err_clr;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt   = 0;
    int pulse_base;

    gpio_irq_arbiter_if #(.ID_W(5)) bus ();

    gpio_irq_arbiter #(
        .NUM_PINS (24),
        .ID_W     (5),
        .CLR_WAIT (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .intr     (intr),
        .irq_mask (irq_mask),
        .irqres   (irqres),
        .pending  (pending),
        .clr_err  (clr_err),
        .err_clr  (err_clr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Counts clear strobes seen by the pin mux side.
    always @(negedge clk) begin
        if (irqres != '0) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        intr        = '0;
        irq_mask    = 24'hFFFFFF;
        err_clr     = 1'b0;
        bus.irq_ack = 1'b0;
        #2;
        check("rst_irq", 32'(bus.irq), 0);
        check("rst_id", 32'(bus.irq_id), 0);
        check("rst_irqres", 32'(irqres), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_clr_err", 32'(clr_err), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single source, full handshake
        intr = 24'h000001;
        tick();
        check("t1_irq_early", 32'(bus.irq), 0);
        tick();
        check("t1_irq", 32'(bus.irq), 1);
        check("t1_id", 32'(bus.irq_id), 0);
        check("t1_pending", 32'(pending), 32'h1);
        bus.irq_ack = 1'b1;
        tick();
        check("t1_irqres", 32'(irqres), 32'h1);
        check("t1_irq_drop", 32'(bus.irq), 0);
        bus.irq_ack = 1'b0;
        intr        = '0;
        tick();
        check("t1_irqres_off", 32'(irqres), 0);
        tick();
        tick();
        check("t1_idle_irq", 32'(bus.irq), 0);
        check("t1_clr_err", 32'(clr_err), 0);

        // Fixed priority: 4 before 23
        intr = 24'h800010;
        tick();
        tick();
        check("t2_id4", 32'(bus.irq_id), 4);
        bus.irq_ack = 1'b1;
        tick();
        check("t2_irqres4", 32'(irqres), 32'h10);
        bus.irq_ack = 1'b0;
        intr        = 24'h800000;
        tick();
        tick();
        tick();
        check("t2_irq23", 32'(bus.irq), 1);
        check("t2_id23", 32'(bus.irq_id), 23);
        bus.irq_ack = 1'b1;
        tick();
        check("t2_irqres23", 32'(irqres), 32'h800000);
        bus.irq_ack = 1'b0;
        intr        = '0;
        tick();
        tick();
        tick();

        // Masking
        irq_mask = 24'hFFFFEF;
        intr     = 24'h000010;
        tick();
        tick();
        tick();
        check("t3_masked_irq", 32'(bus.irq), 0);
        check("t3_masked_pending", 32'(pending), 0);
        irq_mask = 24'hFFFFFF;
        tick();
        check("t3_unmask_irq", 32'(bus.irq), 1);
        check("t3_unmask_id", 32'(bus.irq_id), 4);
        irq_mask = 24'hFFFFEF;
        tick();
        check("t3_withdraw_irq", 32'(bus.irq), 0);
        check("t3_withdraw_irqres", 32'(irqres), 0);
        tick();
        check("t3_withdraw_irqres2", 32'(irqres), 0);
        intr     = '0;
        irq_mask = 24'hFFFFFF;
        tick();
        tick();

        // Stuck source 7: clear timeout
        intr = 24'h000080;
        tick();
        tick();
        check("t4_id7", 32'(bus.irq_id), 7);
        bus.irq_ack = 1'b1;
        tick();
        check("t4_irqres7", 32'(irqres), 32'h80);
        bus.irq_ack = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("t4_no_err_yet", 32'(clr_err), 0);
        tick();
        check("t4_err", 32'(clr_err), 1);
        check("t4_err_irq", 32'(bus.irq), 0);
        tick();
        check("t4_rereq_irq", 32'(bus.irq), 1);
        check("t4_rereq_id", 32'(bus.irq_id), 7);
        err_clr = 1'b1;
        tick();
        check("t4_err_cleared", 32'(clr_err), 0);
        err_clr     = 1'b0;
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("t4_no_err_yet2", 32'(clr_err), 0);
        err_clr = 1'b1;
        tick();
        check("t4_set_wins", 32'(clr_err), 1);
        err_clr = 1'b0;
        intr    = '0;
        tick();
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_cleared2", 32'(clr_err), 0);

        // Reset in CLEAR and in WAIT_LOW
        intr = 24'h000004;
        tick();
        tick();
        check("t5_id2", 32'(bus.irq_id), 2);
        bus.irq_ack = 1'b1;
        tick();
        check("t5_irqres", 32'(irqres), 32'h4);
        rst_n       = 1'b0;
        bus.irq_ack = 1'b0;
        #1;
        check("t5_rst_irqres", 32'(irqres), 0);
        check("t5_rst_irq", 32'(bus.irq), 0);
        check("t5_rst_pending", 32'(pending), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_rel_irq_early", 32'(bus.irq), 0);
        check("t5_rel_irqres", 32'(irqres), 0);
        tick();
        check("t5_rel_irq", 32'(bus.irq), 1);
        check("t5_rel_id", 32'(bus.irq_id), 2);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        tick();
        check("t5_wl_pending", 32'(pending), 32'h4);
        rst_n = 1'b0;
        #1;
        check("t5_rst2_pending", 32'(pending), 0);
        check("t5_rst2_irqres", 32'(irqres), 0);
        check("t5_rst2_irq", 32'(bus.irq), 0);
        tick();
        rst_n = 1'b1;
        intr  = '0;
        tick();
        tick();
        check("t5_quiet_irq", 32'(bus.irq), 0);
        check("t5_quiet_irqres", 32'(irqres), 0);

        // ACK held high: two sources serviced back to back
        pulse_base  = pulse_cnt;
        bus.irq_ack = 1'b1;
        intr        = 24'h000003;
        tick();
        check("t6_idle_ack_irqres", 32'(irqres), 0);
        tick();
        check("t6_id0", 32'(bus.irq_id), 0);
        check("t6_irq0", 32'(bus.irq), 1);
        tick();
        check("t6_irqres0", 32'(irqres), 32'h1);
        intr = 24'h000002;
        tick();
        check("t6_irqres_gap", 32'(irqres), 0);
        tick();
        tick();
        check("t6_id1", 32'(bus.irq_id), 1);
        check("t6_irq1", 32'(bus.irq), 1);
        tick();
        check("t6_irqres1", 32'(irqres), 32'h2);
        intr = '0;
        tick();
        tick();
        tick();
        tick();
        check("t6_irqres_idle", 32'(irqres), 0);
        check("t6_pulse_count", 32'(pulse_cnt - pulse_base), 2);
        bus.irq_ack = 1'b0;

`ifdef GPIO_IRQ_RR_EN
        // Round robin: after servicing 4, pin 5 beats pin 4
        intr = 24'h000010;
        tick();
        tick();
        check("rr_id4", 32'(bus.irq_id), 4);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        intr        = '0;
        tick();
        tick();
        tick();
        intr = 24'h000030;
        tick();
        tick();
        check("rr_id5", 32'(bus.irq_id), 5);
        intr = '0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
